// File: rtl/ycc_rgb_mcu_stream.sv
// Gathers one Y/Cb/Cr MCU (three 8x8 blocks) and streams it as 64 RGB
// pixels in raster order using fixed-point JFIF conversion with clamping.
module ycc_rgb_mcu_stream (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            ch,
    input  logic                  valid_in,
    input  logic [7:0][7:0][7:0]  block_in,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  valid_out,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b,
    output logic [2:0]            row,
    output logic [2:0]            col,
    output logic                  mcu_done
);

    typedef enum logic {LOAD, STREAM} state_t;

    state_t               state;
    logic [2:0]           mask;
    logic [5:0]           p;
    logic [7:0][7:0][7:0] buf_y;
    logic [7:0][7:0][7:0] buf_cb;
    logic [7:0][7:0][7:0] buf_cr;

    logic                 accept;
    logic [2:0]           ch_bit;
    logic [2:0]           mask_nxt;
    logic                 fire;

    assign in_ready  = (state == LOAD);
    assign valid_out = (state == STREAM);
    assign row       = p[5:3];
    assign col       = p[2:0];
    assign accept    = in_ready && valid_in && (ch <= 2'd2);
    assign ch_bit    = 3'b001 << ch;
    assign mask_nxt  = mask | ch_bit;
    assign fire      = valid_out && out_ready;

    // Control FSM: collect channel mask, then walk the pixel index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= LOAD;
            mask     <= 3'b000;
            p        <= 6'd0;
            mcu_done <= 1'b0;
        end else begin
            mcu_done <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        mask <= mask_nxt;
                        if (mask_nxt == 3'b111) begin
                            state <= STREAM;
                            p     <= 6'd0;
                        end
                    end
                end
                STREAM: begin
                    if (fire) begin
                        if (p == 6'd63) begin
                            state    <= LOAD;
                            mask     <= 3'b000;
                            p        <= 6'd0;
                            mcu_done <= 1'b1;
                        end else begin
                            p <= p + 6'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Block buffers; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            case (ch)
                2'd0:    buf_y  <= block_in;
                2'd1:    buf_cb <= block_in;
                2'd2:    buf_cr <= block_in;
                default: ;
            endcase
        end
    end

    function automatic logic [7:0] sat(input logic signed [19:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 20'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    logic [7:0]          y_s;
    logic [7:0]          cb_s;
    logic [7:0]          cr_s;
    logic signed [19:0]  y_w;
    logic signed [19:0]  d_b;
    logic signed [19:0]  d_r;
    logic signed [19:0]  r_raw;
    logic signed [19:0]  g_raw;
    logic signed [19:0]  b_raw;

    // Color conversion of the current pixel; zeroed when not streaming.
    always_comb begin
        y_s   = buf_y[row][col];
        cb_s  = buf_cb[row][col];
        cr_s  = buf_cr[row][col];
        y_w   = $signed({12'd0, y_s});
        d_b   = $signed({12'd0, cb_s}) - 20'sd128;
        d_r   = $signed({12'd0, cr_s}) - 20'sd128;
        r_raw = y_w + ((20'sd359 * d_r) >>> 8);
        g_raw = y_w + (((-20'sd88) * d_b - 20'sd183 * d_r) >>> 8);
        b_raw = y_w + ((20'sd454 * d_b) >>> 8);
        r     = 8'd0;
        g     = 8'd0;
        b     = 8'd0;
        if (valid_out) begin
            r = sat(r_raw);
            g = sat(g_raw);
            b = sat(b_raw);
        end
    end

endmodule

// File: tb/tb_ycc_rgb_mcu_stream.sv
// Self-checking bench for ycc_rgb_mcu_stream: table vectors, ordering,
// backpressure with random data against a reference model, and reset abort.
module tb_ycc_rgb_mcu_stream;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [1:0]           ch;
    logic                 valid_in;
    logic [7:0][7:0][7:0] block_in;
    logic                 in_ready;
    logic                 out_ready;
    logic                 valid_out;
    logic [7:0]           r, g, b;
    logic [2:0]           row, col;
    logic                 mcu_done;

    ycc_rgb_mcu_stream dut (
        .clock(clock), .reset(reset), .ch(ch), .valid_in(valid_in),
        .block_in(block_in), .in_ready(in_ready), .out_ready(out_ready),
        .valid_out(valid_out), .r(r), .g(g), .b(b), .row(row), .col(col),
        .mcu_done(mcu_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int y, cb, cr;
        int er, eg, eb;
    } vec_t;

    int checks = 0;
    int errors = 0;

    byte unsigned ym[64], cbm[64], crm[64], junk[64];
    int           exr[64], exg[64], exb[64];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int fdiv256(input int x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    function automatic int clamp8(input int x);
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    task automatic model();
        for (int i = 0; i < 64; i++) begin
            int yy, db, dr;
            yy = ym[i];
            db = int'(cbm[i]) - 128;
            dr = int'(crm[i]) - 128;
            exr[i] = clamp8(yy + fdiv256(359 * dr));
            exg[i] = clamp8(yy + fdiv256(-88 * db - 183 * dr));
            exb[i] = clamp8(yy + fdiv256(454 * db));
        end
    endtask

    task automatic randomize_mcu();
        for (int i = 0; i < 64; i++) begin
            ym[i]  = 8'($urandom);
            cbm[i] = 8'($urandom);
            crm[i] = 8'($urandom);
        end
        model();
    endtask

    task automatic load(input logic [1:0] c, input byte unsigned src[64]);
        for (int i = 0; i < 64; i++) block_in[i / 8][i % 8] = src[i];
        ch = c;
        valid_in = 1'b1;
        @(negedge clock);
        valid_in = 1'b0;
    endtask

    task automatic stream(input int stop_at, input int duty, input bit inj);
        int p = 0;
        int cyc = 0;
        bit fire = 0;
        bit have = 0;
        logic [7:0] pr, pg, pb;
        logic [2:0] prow, pcol;
        while (p < stop_at && cyc < 3000) begin
            chk("valid_out", valid_out, 1);
            chk("in_ready_stream", in_ready, 0);
            chk("mcu_done_stream", mcu_done, 0);
            chk("row", row, p / 8);
            chk("col", col, p % 8);
            chk("r", r, exr[p]);
            chk("g", g, exg[p]);
            chk("b", b, exb[p]);
            if (have && !fire) begin
                chk("stall_r", r, pr);
                chk("stall_g", g, pg);
                chk("stall_b", b, pb);
                chk("stall_rowcol", {row, col}, {prow, pcol});
            end
            pr = r; pg = g; pb = b; prow = row; pcol = col;
            have = 1;
            fire = ($urandom_range(0, 99) < duty);
            out_ready = fire;
            if (inj) begin
                valid_in = 1'($urandom);
                ch = 2'($urandom_range(0, 2));
                for (int i = 0; i < 64; i++)
                    block_in[i / 8][i % 8] = 8'($urandom);
            end
            @(negedge clock);
            cyc++;
            if (fire) p++;
        end
        out_ready = 1'b0;
        valid_in = 1'b0;
        if (p < stop_at) begin
            chk("stream_timeout", p, stop_at);
        end else if (stop_at == 64) begin
            if (duty >= 100) chk("stream_cycles", cyc, 64);
            chk("mcu_done_pulse", mcu_done, 1);
            chk("in_ready_done", in_ready, 1);
            chk("valid_out_done", valid_out, 0);
            chk("r_idle", r, 0);
            @(negedge clock);
            chk("mcu_done_once", mcu_done, 0);
        end
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{128, 128, 128, 128, 128, 128};
        tbl[1] = '{255, 128, 255, 255, 164, 255};
        tbl[2] = '{0,   0,   128, 0,   44,  0};
        tbl[3] = '{100, 128, 200, 200, 48,  100};

        reset = 1'b1;
        valid_in = 1'b0;
        out_ready = 1'b0;
        ch = 2'd0;
        block_in = '0;
        #12;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rgb", {r, g, b}, 0);
        chk("rst_rowcol", {row, col}, 0);
        chk("rst_mcu_done", mcu_done, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Uniform-block vectors in order Y, Cb, Cr with out_ready held high.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 64; i++) begin
                ym[i]  = 8'(tbl[t].y);
                cbm[i] = 8'(tbl[t].cb);
                crm[i] = 8'(tbl[t].cr);
                exr[i] = tbl[t].er;
                exg[i] = tbl[t].eg;
                exb[i] = tbl[t].eb;
            end
            load(2'd0, ym);
            chk("early_after_y", valid_out, 0);
            load(2'd1, cbm);
            chk("early_after_cb", valid_out, 0);
            load(2'd2, crm);
            stream(64, 100, 0);
        end

        // Out-of-order, duplicate and illegal-channel blocks.
        for (int i = 0; i < 64; i++) begin
            ym[i]  = 8'd100;
            cbm[i] = 8'd128;
            crm[i] = 8'd10;
            junk[i] = 8'($urandom);
            exr[i] = tbl[3].er;
            exg[i] = tbl[3].eg;
            exb[i] = tbl[3].eb;
        end
        load(2'd2, crm);
        chk("order_cr1", valid_out, 0);
        for (int i = 0; i < 64; i++) crm[i] = 8'd200;
        load(2'd2, crm);
        chk("order_cr2", valid_out, 0);
        load(2'd3, junk);
        chk("order_ch3", valid_out, 0);
        load(2'd0, ym);
        chk("order_y", valid_out, 0);
        load(2'd1, cbm);
        stream(64, 100, 0);

        // Random data under 30% backpressure with upstream pushing.
        for (int t = 0; t < 2; t++) begin
            randomize_mcu();
            load(2'd1, cbm);
            load(2'd0, ym);
            load(2'd2, crm);
            stream(64, 30, 1);
        end

        // Reset abort at pixel 20, then a fresh MCU.
        randomize_mcu();
        load(2'd0, ym);
        load(2'd1, cbm);
        load(2'd2, crm);
        stream(20, 100, 0);
        reset = 1'b1;
        #1;
        chk("abort_valid_out", valid_out, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_mcu_done", mcu_done, 0);
        chk("abort_rgb", {r, g, b}, 0);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_no_done", mcu_done, 0);
        randomize_mcu();
        load(2'd2, crm);
        load(2'd1, cbm);
        chk("fresh_partial", valid_out, 0);
        load(2'd0, ym);
        stream(64, 50, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ycc_rgb_mcu_stream.md
# ycc_rgb_mcu_stream

Downstream consumer of the chroma supersampler. Collects one full-resolution 8x8 Y block and the two supersampled 8x8 Cb and Cr blocks of an MCU into internal buffers. Then streams the MCU out as 64 RGB pixels in raster order, one per accepted handshake. Each pixel uses fixed-point JFIF color conversion with saturation.

## Interface
- No parameters; channel-select width is `$clog2(`CH+1)` from sys_defs.svh (Y=0, Cb=1, Cr=2).
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ch  input  $clog2(`CH+1)  channel of block_in.
- valid_in  input  1  block_in/ch valid this cycle.
- block_in  input  8 x [7:0][7:0]  unsigned 8-bit samples, [row][col].
- in_ready  output  1  block accepted at edge when valid_in && in_ready.
- out_ready  input  1  downstream accepts current pixel.
- valid_out  output  1  r/g/b/row/col valid.
- r, g, b  output  8 each  saturated pixel components.
- row, col  output  3 each  position of current pixel within 8x8 block.
- mcu_done  output  1  one-cycle pulse after last pixel of an MCU is accepted.

## Operation
- Two-state FSM: LOAD, STREAM. Reset state LOAD.
- LOAD: in_ready=1. On valid_in with ch in {0,1,2}: copy block_in into that channel's 64-byte buffer and set that bit of a 3-bit received mask. Channels may arrive in any order.
- A repeat of an already-received channel overwrites its buffer. Mask is unchanged.
- ch=3 (or any value >2) with valid_in: ignored. Buffer and mask are unchanged.
- When an accepted block makes mask==3'b111: next state STREAM, pixel index cleared to 0.
- STREAM: in_ready=0 and valid_in is ignored. Upstream holds its block until LOAD resumes.
- STREAM: valid_out=1; pixel index p (0..63) gives row=p[5:3], col=p[2:0].
- Handshake fires when valid_out && out_ready: p increments. Otherwise p, r, g, b, row and col hold stable.
- Handshake at p=63: next state LOAD, mask cleared, p=0, mcu_done=1 for the following cycle only.
- Conversion uses Y, Cb, Cr from the buffers at (row,col). Let d_b=Cb-128 and d_r=Cr-128 (signed, 9-bit).
  - R = Y + ((359*d_r) >>> 8)
  - G = Y + ((-88*d_b - 183*d_r) >>> 8)
  - B = Y + ((454*d_b) >>> 8)
- Products and sums are computed signed in at least 19 bits. `>>>` is an arithmetic shift (floor toward -inf).
- Each result is clamped: <0 gives 0, >255 gives 255.
- r, g, b are combinational from buffers and p. They are forced to 0 whenever valid_out=0.

## Timing
- Reset values: valid_out=0, in_ready=1, r=g=b=0, row=col=0, mcu_done=0, mask=0, state LOAD. Buffer contents are don't-care.
- Reset asserted mid-LOAD or mid-STREAM aborts the MCU. Outputs take reset values asynchronously. First block after deassertion starts a fresh MCU.
- Completing block accepted at edge N: valid_out=1 from cycle N+1 with pixel 0.
- With out_ready held 1: pixels 0..63 appear on cycles N+1..N+64. mcu_done=1 in cycle N+65, alongside in_ready=1.
- Best-case MCU throughput: 3 load cycles + 64 stream cycles.
- out_ready may toggle arbitrarily. No pixel is skipped or duplicated.
- in_ready depends only on state, never combinationally on valid_in or out_ready.
- mcu_done and in_ready=1 in the same cycle is legal. A block arriving that cycle is accepted into the new MCU.

## Test plan
- Gray: Y=Cb=Cr all 128, loaded in order Y, Cb, Cr, out_ready=1 -> 64 pixels r=g=b=128, raster row/col 0..7. mcu_done pulses once at cycle N+65.
- Saturation high: Y=255, Cb=128, Cr=255 -> r=255, g=164 (255-91), b=255 on every pixel.
- Saturation low / floor rounding: Y=0, Cb=0, Cr=128 -> r=0, g=44, b=0 (raw B = -227 clamped).
- Order, duplicate and illegal channel:
  - Stimulus: Cr=10, Cr=200 (overwrite), ch=3, Y=100, Cb=128.
  - Streaming starts only after Cb is accepted.
  - Every pixel gives r=100+((359*72)>>>8)=200, g=100+((-183*72)>>>8)=48, b=100.
- Backpressure: random out_ready at 30% duty -> exactly 64 distinct pixels in order. r/g/b/row/col are stable while stalled. valid_in during STREAM is never accepted.
- Reset mid-stream: assert reset at pixel 20 -> valid_out=0 and in_ready=1 immediately, no mcu_done. A new full MCU then streams correctly from pixel 0.
